booth_seq_ctrl: RTL

//  Sequencer for the radix-2 Booth multiplier datapath (mult).
//  - Accepts a start request from the host and pulses the datapath operand load.
//  - Inspects the Booth pair on Q_out each iteration and issues one-hot add_s/sub_s/ashift_s strobes.
//  - Counts N_LEN iterations, then signals completion to both datapath and host.

---
 rtl/booth_seq_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer: loads operands, steps add/sub/shift
// strobes from the Booth pair, and flags completion after N_LEN iterations.
module booth_seq_ctrl #(
  parameter int N_LEN = 8,
  localparam int IW = (N_LEN > 2) ? $clog2(N_LEN) : 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [2:0]    Q_out,
  output logic          Request,
  output logic          Done,
  output logic          add_s,
  output logic          sub_s,
  output logic          ashift_s,
  output logic          Busy,
  output logic [IW-1:0] Iter
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    SHIFT = 3'd5,
    FIN   = 3'd6
  } state_t;

  localparam logic [IW-1:0] ITER_LAST = IW'(N_LEN - 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] iter;
  logic [IW-1:0] iter_nx;
  logic          last;

  assign last = (iter == ITER_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_nx;
      iter  <= iter_nx;
    end
  end

  // Q_out only steers the CHECK branch; it never reaches an output.
  always_comb begin
    state_nx = state;
    iter_nx  = iter;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = LOAD;
      end
      LOAD: begin
        iter_nx  = '0;
        state_nx = CHECK;
      end
      CHECK: begin
        unique case (Q_out[1:0])
          2'b10:   state_nx = SUB;
          2'b01:   state_nx = ADD;
          default: state_nx = SHIFT;
        endcase
      end
      ADD, SUB: begin
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (last) begin
          state_nx = FIN;
        end else begin
          iter_nx  = iter + 1'b1;
          state_nx = CHECK;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        iter_nx  = '0;
      end
    endcase
  end

  always_comb begin
    Request  = 1'b0;
    Done     = 1'b0;
    add_s    = 1'b0;
    sub_s    = 1'b0;
    ashift_s = 1'b0;
    Busy     = (state != IDLE);
    unique case (state)
      LOAD:    Request  = 1'b1;
      ADD:     add_s    = 1'b1;
      SUB:     sub_s    = 1'b1;
      SHIFT:   ashift_s = 1'b1;
      FIN:     Done     = 1'b1;
      default: ;
    endcase
  end

  assign Iter = iter;

endmodule
